fa_1bit: RTL and testbench
==========================

FA_1BIT -- requirements
Module: fa_1bit

Interface
REQ-001 Parameter CARRY_INIT, default 1'b0: reset value of the serial carry register; only used when FA_1BIT_SERIAL_EN is defined.
REQ-002 clk  input  1  single clock; all registers update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 cin  input  1  carry-in bit.
REQ-007 sum  output  1  combinational sum bit.
REQ-008 cout  output  1  combinational carry-out bit.
REQ-009 sum_q  output  1  sum, registered.
REQ-010 cout_q  output  1  cout, registered.
REQ-011 serial_en  input  1  serial-add mode enable; this port exists only with FA_1BIT_SERIAL_EN.
REQ-012 serial_start  input  1  marks the first (LSB) bit of a serial word; this port exists only with FA_1BIT_SERIAL_EN.

Function
REQ-013 The effective carry c_eff SHALL equal cin, except in serial mode (see REQ-021).
REQ-014 sum SHALL equal a XOR b XOR c_eff, purely combinationally, with zero clock latency.
REQ-015 cout SHALL equal (a AND b) OR (a AND c_eff) OR (b AND c_eff), i.e. majority, purely combinationally.
REQ-016 {cout,sum} SHALL equal the 2-bit arithmetic sum a+b+c_eff for all 8 input combinations; there are no X/Z-propagation special cases.
REQ-017 sum and cout SHALL be valid without any clock edge and SHALL be independent of rst.
REQ-018 On each rising clk edge with rst low, sum_q and cout_q SHALL capture sum and cout, giving 1-cycle latency.
REQ-019 The combinational outputs SHALL contain no latches and no combinational loops.

Reset
REQ-020 While rst is high, sum_q=0 and cout_q=0 (and carry_q=CARRY_INIT with the macro), asynchronously; registers resume on the first rising edge after rst falls. rst asserted mid-operation SHALL discard the serial carry in progress.

Configuration
REQ-021 With FA_1BIT_SERIAL_EN defined:
- The ports serial_en and serial_start SHALL be added, together with an internal carry_q register.
- When serial_en=1 and serial_start=1, c_eff SHALL be cin.
- When serial_en=1 and serial_start=0, c_eff SHALL be carry_q.
- Every rising edge with serial_en=1 SHALL load carry_q with cout.
- With serial_en=0, carry_q SHALL hold its value and c_eff SHALL be cin.
REQ-022 Without FA_1BIT_SERIAL_EN, neither the serial ports nor carry_q SHALL exist, and c_eff SHALL be cin always.

Structure
REQ-023 Package fa_1bit_pkg SHALL hold the CARRY_INIT default constant and the typedef fa_res_t (packed struct {cout, sum}).
REQ-024 The combinational add SHALL be a sub-module fa_1bit_core (a, b, c -> sum, cout), instantiated once; the registers and serial logic live in fa_1bit.

Verification
REQ-025 Exhaustive test: step {a,b,cin} 000..111 -> {cout,sum} = 00,01,01,10,01,10,10,11.
REQ-026 Toggle test: toggle cin every 1 ns, b every 2 ns, a every 4 ns, all starting at 0, for 30 ns -> all 8 combinations are covered, and sum/cout match REQ-016 at every step with no clock running.
REQ-027 Register test: a=1, b=1, cin=0, one clk edge -> sum_q=0, cout_q=1; assert rst between edges -> sum_q=0, cout_q=0 immediately.
REQ-028 Serial test (macro on): add 4-bit words 0111 and 0011 LSB-first, serial_start on bit 0, cin=0 -> sum bits (LSB-first) 0,1,0,1 and final cout 0, i.e. result 1010 = 10.
REQ-029 Serial reset test (macro on): pulse rst after bit 1 -> carry_q returns to CARRY_INIT; next word with serial_start=1 adds correctly.

Source files
------------

// File: rtl/fa_1bit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_1bit_pkg
// Description : Shared constants and types for the 1-bit full adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fa_1bit_pkg;

    // Reset value of the serial carry register when no override is given
    localparam logic c_CARRY_INIT_DEFAULT = 1'b0;

    // Two-bit adder result, MSB is the carry-out
    typedef struct packed {
        logic cout;
        logic sum;
    } fa_res_t;

endpackage : fa_1bit_pkg
`default_nettype wire

// File: rtl/fa_1bit_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_1bit_core
// Description : Purely combinational 1-bit full adder (a + b + c).
// Revision    : 1.0 - initial release
// ============================================================================
module fa_1bit_core
    import fa_1bit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    fa_res_t w_res;

    // Sum is odd parity of the three inputs, carry is their majority
    always_comb begin
        w_res.sum  = a ^ b ^ c;
        w_res.cout = (a & b) | (a & c) | (b & c);
    end

    assign sum  = w_res.sum;
    assign cout = w_res.cout;

endmodule : fa_1bit_core
`default_nettype wire

// File: rtl/fa_1bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fa_1bit
// Description : 1-bit full adder with registered copies of sum/cout.
//               Optional macro FA_1BIT_SERIAL_EN adds a bit-serial mode in
//               which the carry is recirculated through an internal register
//               so multi-bit words can be added LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_1bit
    import fa_1bit_pkg::*;
#(
    parameter logic CARRY_INIT = c_CARRY_INIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
`ifdef FA_1BIT_SERIAL_EN
    input  logic serial_en,
    input  logic serial_start,
`endif
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q
);

    logic w_c_eff;
    logic w_sum;
    logic w_cout;
    logic r_sum_q;
    logic r_cout_q;

`ifdef FA_1BIT_SERIAL_EN
    logic r_carry_q;

    // Mid-word bits take the carry recirculated from the previous bit
    assign w_c_eff = (serial_en && !serial_start) ? r_carry_q : cin;

    // Carry register advances only while serial mode is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_q <= CARRY_INIT;
        end else if (serial_en) begin
            r_carry_q <= w_cout;
        end
    end
`else
    // Parameter only matters in serial mode; tie it off here
    logic w_unused_carry_init;
    assign w_unused_carry_init = CARRY_INIT;

    assign w_c_eff = cin;
`endif

    fa_1bit_core u_core (
        .a    (a),
        .b    (b),
        .c    (w_c_eff),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Registered copy of the adder result, one cycle behind the inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q  <= 1'b0;
            r_cout_q <= 1'b0;
        end else begin
            r_sum_q  <= w_sum;
            r_cout_q <= w_cout;
        end
    end

    assign sum    = w_sum;
    assign cout   = w_cout;
    assign sum_q  = r_sum_q;
    assign cout_q = r_cout_q;

endmodule : fa_1bit
`default_nettype wire

// File: tb/tb_fa_1bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fa_1bit
// Description : Self-checking bench for fa_1bit; reference results are
//               computed arithmetically (a+b+c, word sums) in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_1bit;

    localparam logic c_TB_CARRY_INIT = 1'b1;

    logic clk;
    logic clk_run;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic sum_q;
    logic cout_q;
`ifdef FA_1BIT_SERIAL_EN
    logic serial_en;
    logic serial_start;
    int   last_carry;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fa_1bit #(
        .CARRY_INIT (c_TB_CARRY_INIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .cin          (cin),
`ifdef FA_1BIT_SERIAL_EN
        .serial_en    (serial_en),
        .serial_start (serial_start),
`endif
        .sum          (sum),
        .cout         (cout),
        .sum_q        (sum_q),
        .cout_q       (cout_q)
    );

    // Clock only toggles once the combinational phase is over
    always #5 begin
        if (clk_run) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

`ifdef FA_1BIT_SERIAL_EN
    // Add two 4-bit words LSB-first; expected bits come from the integer sum
    task automatic serial_word(input logic [3:0] wa, input logic [3:0] wb, input logic wc);
        int total;
        total = int'(wa) + int'(wb) + int'(wc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a            = wa[i];
            b            = wb[i];
            cin          = (i == 0) ? wc : 1'($urandom_range(0, 1));
            serial_start = (i == 0);
            #1;
            chk("ser_sum", int'(sum), (total >> i) & 1);
            if (i == 3) chk("ser_cout", int'(cout), (total >> 4) & 1);
            @(posedge clk);
            #1;
            chk("ser_sum_q", int'(sum_q), (total >> i) & 1);
        end
        last_carry = (total >> 4) & 1;
    endtask
`endif

    initial begin
        int          exp_tbl [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
        logic [7:0]  seen;
        logic [2:0]  v;
        int          ra, rb, rc, tot;

        clk     = 1'b0;
        clk_run = 1'b0;
        rst     = 1'b1;
        a       = 1'b0;
        b       = 1'b0;
        cin     = 1'b0;
`ifdef FA_1BIT_SERIAL_EN
        serial_en    = 1'b0;
        serial_start = 1'b0;
        last_carry   = 0;
`endif
        #1;
        chk("rst_sum_q", int'(sum_q), 0);
        chk("rst_cout_q", int'(cout_q), 0);

        // Exhaustive sweep, no clock, reset held (comb path ignores rst)
        for (int i = 0; i < 8; i++) begin
            v   = 3'(i);
            a   = v[2];
            b   = v[1];
            cin = v[0];
            #1;
            chk("exh", int'({cout, sum}), exp_tbl[i]);
        end

        // Toggle pattern: cin every 1 ns, b every 2 ns, a every 4 ns
        seen = '0;
        for (int t = 0; t < 30; t++) begin
            a   = 1'((t >> 2) & 1);
            b   = 1'((t >> 1) & 1);
            cin = 1'(t & 1);
            #0.5;
            seen[{a, b, cin}] = 1'b1;
            chk("tgl", int'({cout, sum}), int'(a) + int'(b) + int'(cin));
            #0.5;
        end
        chk("tgl_cover", int'(seen), 255);

        // Release reset and start the clock
        rst     = 1'b0;
        clk_run = 1'b1;

        // Random non-serial traffic: comb now, registered one edge later
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            ra  = int'($urandom_range(0, 1));
            rb  = int'($urandom_range(0, 1));
            rc  = int'($urandom_range(0, 1));
            a   = 1'(ra);
            b   = 1'(rb);
            cin = 1'(rc);
            tot = ra + rb + rc;
            #1;
            chk("rnd_comb", int'({cout, sum}), tot);
            @(posedge clk);
            #1;
            chk("rnd_reg", int'({cout_q, sum_q}), tot);
        end

        // Register test with asynchronous reset between edges
        @(negedge clk);
        a   = 1'b1;
        b   = 1'b1;
        cin = 1'b0;
        @(posedge clk);
        #1;
        chk("reg_sum_q", int'(sum_q), 0);
        chk("reg_cout_q", int'(cout_q), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sum_q", int'(sum_q), 0);
        chk("arst_cout_q", int'(cout_q), 0);
        chk("arst_comb", int'({cout, sum}), 2);
        @(negedge clk);
        rst = 1'b0;

`ifdef FA_1BIT_SERIAL_EN
        serial_en = 1'b1;
        serial_word(4'b0111, 4'b0011, 1'b0);
        for (int n = 0; n < 6; n++) begin
            serial_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
        end

        // Carry must hold while serial mode is off
        serial_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        serial_en    = 1'b1;
        serial_start = 1'b0;
        a            = 1'b0;
        b            = 1'b0;
        cin          = ~1'(last_carry);
        #1;
        chk("ser_hold", int'(sum), last_carry);

        // Two zero bits leave carry 0, then reset restores CARRY_INIT
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a            = 1'b0;
            b            = 1'b0;
            cin          = 1'b0;
            serial_start = (i == 0);
        end
        @(posedge clk);
        @(negedge clk);
        serial_start = 1'b0;
        #1;
        chk("ser_pre_rst", int'(sum), 0);
        rst = 1'b1;
        #1;
        chk("ser_rst_carry", int'({cout, sum}), int'(c_TB_CARRY_INIT));
        rst = 1'b0;
        serial_word(4'b1001, 4'b0101, 1'b1);
        serial_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        serial_en = 1'b0;
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fa_1bit
`default_nettype wire
